// File: rtl/fpu_norm_pkg.sv
// Shared definitions for the normalizer-sharing block.
//   DEF_NUM_REQ / DEF_LEN : default requester count and mantissa width
//   id_width() / sh_width(): derive requester-index and shift-amount widths
//   norm_result_t          : one normalized result {id, shamt, norm, zero}
//                            sized for the default parameters
package fpu_norm_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_LEN     = 24;

    // Never return 0 so that single-entry cases still get a 1-bit field.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int id_width(input int num_req);
        return clog2_min1(num_req);
    endfunction

    function automatic int sh_width(input int len);
        return clog2_min1(len);
    endfunction

    localparam int DEF_ID_W = id_width(DEF_NUM_REQ);
    localparam int DEF_SH_W = sh_width(DEF_LEN);

    typedef struct packed {
        logic [DEF_ID_W-1:0] id;
        logic [DEF_SH_W-1:0] shamt;
        logic [DEF_LEN-1:0]  norm;
        logic                zero;
    } norm_result_t;

endpackage

// File: rtl/norm_share_arb_rr_arb.sv
// Round-robin arbiter, purely combinational.
//   req   : request vector
//   ptr   : highest-priority index; scanning proceeds ptr, ptr+1, ... mod N
//   grant : one-hot grant (all zero when no request)
module rr_arb #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/norm_share_arb.sv
// One leading-zero-count + left-normalize pipeline shared by NUM_REQ
// requesters through a round-robin arbiter. Two register stages:
// s1 holds the accepted operand and its id, s2 holds the normalized result.
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_ready  : per-requester handshake (ready is combinational)
//   req_data             : operands, requester i at [i*LEN +: LEN]
//   out_valid/out_ready  : result handshake
//   out_id               : requester index of the result
//   out_shamt            : leading-zero count (LEN-1 for a zero operand)
//   out_norm             : operand << out_shamt (0 for a zero operand)
//   out_zero             : operand was all-zero
// Optional (macro NORM_SHARE_ARB_PERF_EN):
//   perf_conflict_cnt    : cycles with more than one req_valid bit high
//   perf_stall_cnt       : cycles with out_valid & !out_ready
//   Both saturate at all-ones.
module norm_share_arb
    import fpu_norm_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int LEN     = DEF_LEN,
    parameter int ID_W    = id_width(NUM_REQ),
    parameter int SH_W    = sh_width(LEN)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*LEN-1:0] req_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ID_W-1:0]        out_id,
    output logic [SH_W-1:0]        out_shamt,
    output logic [LEN-1:0]         out_norm,
`ifdef NORM_SHARE_ARB_PERF_EN
    output logic                   out_zero,
    output logic [31:0]            perf_conflict_cnt,
    output logic [31:0]            perf_stall_cnt
`else
    output logic                   out_zero
`endif
);

    logic [ID_W-1:0]    rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               accept;
    logic               s1_load;
    logic               s2_load;

    logic               s1_valid;
    logic [LEN-1:0]     s1_data;
    logic [ID_W-1:0]    s1_id;

    int                 lz_cnt;
    logic               s1_found;
    logic               s1_zero;
    logic [SH_W-1:0]    s1_shamt;
    logic [LEN-1:0]     s1_norm;

    rr_arb #(
        .N     (NUM_REQ),
        .PTR_W (ID_W)
    ) u_rr_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    // s1 may load when empty or when its content moves on to s2 this cycle.
    assign s2_load   = !out_valid || out_ready;
    assign s1_load   = !s1_valid || s2_load;
    assign req_ready = s1_load ? grant : '0;
    // grant only has bits where req_valid is set, so any ready bit is a handshake.
    assign accept    = |req_ready;

    always_comb begin
        grant_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) grant_id = ID_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_id    <= '0;
        end else begin
            if (accept) begin
                rr_ptr <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + ID_W'(1);
            end
            if (s1_load) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_data <= req_data[int'(grant_id) * LEN +: LEN];
                    s1_id   <= grant_id;
                end
            end
        end
    end

    // Leading-zero count from the MSB; lz_cnt reaches LEN only for a zero operand.
    always_comb begin
        lz_cnt   = 0;
        s1_found = 1'b0;
        for (int i = LEN - 1; i >= 0; i--) begin
            if (!s1_found) begin
                if (s1_data[i]) s1_found = 1'b1;
                else            lz_cnt   = lz_cnt + 1;
            end
        end
    end

    assign s1_zero  = !s1_found;
    assign s1_shamt = s1_zero ? SH_W'(LEN - 1) : SH_W'(lz_cnt);
    assign s1_norm  = s1_data << s1_shamt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_id    <= '0;
            out_shamt <= '0;
            out_norm  <= '0;
            out_zero  <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_id    <= s1_id;
                out_shamt <= s1_shamt;
                out_norm  <= s1_norm;
                out_zero  <= s1_zero;
            end
        end
    end

`ifdef NORM_SHARE_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_conflict_cnt <= '0;
            perf_stall_cnt    <= '0;
        end else begin
            if (($countones(req_valid) > 1) && (perf_conflict_cnt != '1)) begin
                perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
            end
            if (out_valid && !out_ready && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

    // Requesters must hold valid and data until accepted.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_hold_chk
        a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
            (req_valid[i] && !req_ready[i]) |=>
                (req_valid[i] && $stable(req_data[i*LEN +: LEN])));
    end

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(req_ready));

endmodule

// File: tb/tb_norm_share_arb.sv
module tb_norm_share_arb;
    import fpu_norm_pkg::*;

    localparam int NR  = DEF_NUM_REQ;
    localparam int LEN = DEF_LEN;
    localparam int IDW = DEF_ID_W;
    localparam int SHW = DEF_SH_W;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NR-1:0]       req_valid;
    logic [NR-1:0]       req_ready;
    logic [NR*LEN-1:0]   req_data;
    logic                out_valid;
    logic                out_ready;
    logic [IDW-1:0]      out_id;
    logic [SHW-1:0]      out_shamt;
    logic [LEN-1:0]      out_norm;
    logic                out_zero;
`ifdef NORM_SHARE_ARB_PERF_EN
    logic [31:0]         perf_conflict_cnt;
    logic [31:0]         perf_stall_cnt;
`endif

    norm_share_arb u_dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_data          (req_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_id            (out_id),
        .out_shamt         (out_shamt),
        .out_norm          (out_norm),
`ifdef NORM_SHARE_ARB_PERF_EN
        .out_zero          (out_zero),
        .perf_conflict_cnt (perf_conflict_cnt),
        .perf_stall_cnt    (perf_stall_cnt)
`else
        .out_zero          (out_zero)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: in-flight results in order, each in stage 1 or 2.
    typedef struct {
        norm_result_t res;
        int           stage;
    } item_t;

    item_t          pipe[$];
    int             m_rr;
    int             seen_ids[$];
    int             n_acc_dut;

    logic [NR-1:0]  pend;
    logic [LEN-1:0] pdata [NR];
    bit             rand_mode;
    logic [NR-1:0]  rand_mask;
    int             rand_pct;

    int             n_cmp;
    int             n_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic norm_result_t ref_norm(input int id, input logic [LEN-1:0] x);
        norm_result_t r;
        int           sh;
        r.id = IDW'(id);
        if (x == '0) begin
            r.shamt = SHW'(LEN - 1);
            r.norm  = '0;
            r.zero  = 1'b1;
        end else begin
            sh      = LEN - $clog2(int'(x) + 1);
            r.shamt = SHW'(sh);
            r.norm  = x << sh;
            r.zero  = 1'b0;
        end
        return r;
    endfunction

    function automatic logic exp_ov();
        return (pipe.size() > 0) && (pipe[0].stage == 2);
    endfunction

    // Room exists unless both stages are full and the output is stalled.
    function automatic logic [NR-1:0] exp_ready_f();
        logic [NR-1:0] r;
        int            j;
        r = '0;
        if ((pipe.size() < 2) || out_ready) begin
            for (int k = 0; k < NR; k++) begin
                j = (m_rr + k) % NR;
                if (req_valid[j]) begin
                    r[j] = 1'b1;
                    break;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [LEN-1:0] rand_operand();
        logic [LEN-1:0] v;
        if ($urandom_range(0, 9) == 0) return '0;
        v = LEN'($urandom);
        return v >> $urandom_range(0, LEN - 1);
    endfunction

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]             = pend[i];
            req_data[i*LEN +: LEN]   = pdata[i];
        end
    endtask

    task automatic post(input int i, input logic [LEN-1:0] d);
        pend[i]  = 1'b1;
        pdata[i] = d;
        drive();
    endtask

    task automatic refill();
        for (int i = 0; i < NR; i++) begin
            if (rand_mask[i] && !pend[i] && ($urandom_range(0, 99) < rand_pct)) begin
                pend[i]  = 1'b1;
                pdata[i] = rand_operand();
            end
        end
    endtask

    // One clock: check at negedge, advance the model at posedge, drive at +1.
    task automatic cycle();
        logic [NR-1:0] er;
        logic [NR-1:0] acc_dut;
        item_t         it;
        int            g;
        @(negedge clk);
        er = exp_ready_f();
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("out_valid", 32'(out_valid), 32'(exp_ov()));
        if (exp_ov()) begin
            chk("out_id",    32'(out_id),    32'(pipe[0].res.id));
            chk("out_shamt", 32'(out_shamt), 32'(pipe[0].res.shamt));
            chk("out_norm",  32'(out_norm),  32'(pipe[0].res.norm));
            chk("out_zero",  32'(out_zero),  32'(pipe[0].res.zero));
        end
        if (out_valid && out_ready) seen_ids.push_back(int'(out_id));
        acc_dut = req_ready & req_valid;
        n_acc_dut += $countones(acc_dut);
        @(posedge clk);
        if (exp_ov() && out_ready) void'(pipe.pop_front());
        if ((pipe.size() > 0) && (pipe[0].stage == 1)) begin
            it       = pipe[0];
            it.stage = 2;
            pipe[0]  = it;
        end
        if (er != '0) begin
            g = 0;
            for (int i = 0; i < NR; i++) if (er[i]) g = i;
            it.res   = ref_norm(g, pdata[g]);
            it.stage = 1;
            pipe.push_back(it);
            m_rr = (g + 1) % NR;
        end
        #1;
        pend = pend & ~acc_dut;
        if (rand_mode) refill();
        drive();
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (((pend != '0) || (pipe.size() > 0)) && (n < 30)) begin
            cycle();
            n++;
        end
        chk("drain_in_time", 32'(n < 30), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0;
        int cyc;
        n_cmp = 0; n_err = 0; n_acc_dut = 0;
        m_rr = 0; pend = '0; rand_mode = 0; rand_mask = '1; rand_pct = 0;
        for (int i = 0; i < NR; i++) pdata[i] = '0;
        req_valid = '0; req_data = '0; out_ready = 1'b0;
        rst_n = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_id",    32'(out_id),    32'd0);
        chk("rst_out_shamt", 32'(out_shamt), 32'd0);
        chk("rst_out_norm",  32'(out_norm),  32'd0);
        chk("rst_out_zero",  32'(out_zero),  32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;

        // Single request, two-cycle latency
        out_ready = 1'b1;
        post(0, 24'h000F00);
        cycle();
        cycle();
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_id",    32'(out_id),    32'd0);
        chk("single_shamt", 32'(out_shamt), 32'd12);
        chk("single_norm",  32'(out_norm),  32'hF00000);
        chk("single_zero",  32'(out_zero),  32'd0);
        drain();

        // Zero operand from requester 2 (leaves the pointer at 3)
        post(2, 24'h000000);
        cycle();
        cycle();
        chk("zero_id",    32'(out_id),    32'd2);
        chk("zero_shamt", 32'(out_shamt), 32'd23);
        chk("zero_norm",  32'(out_norm),  32'd0);
        chk("zero_zero",  32'(out_zero),  32'd1);
        drain();

        // Wrap: pointer at 3, requesters 0 and 3 -> 3 first, then 0
        seen_ids.delete();
        post(0, 24'h000001);
        post(3, 24'h800000);
        drain();
        chk("wrap_count",  32'(seen_ids.size()), 32'd2);
        chk("wrap_first",  32'(seen_ids.size() > 0 ? seen_ids[0] : -1), 32'd3);
        chk("wrap_second", 32'(seen_ids.size() > 1 ? seen_ids[1] : -1), 32'd0);

        // Bring the pointer back to 0 (pointer is 1, only requester 3 asks)
        post(3, 24'h0000F0);
        drain();

        // Fairness: all four held high, one result per cycle after fill
        seen_ids.delete();
        rand_mode = 1; rand_mask = '1; rand_pct = 100;
        refill();
        drive();
        cyc = 0;
        while ((seen_ids.size() < 8) && (cyc < 40)) begin
            cycle();
            cyc++;
        end
        rand_mode = 0;
        chk("fair_cycles", 32'(cyc), 32'd10);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fair_id%0d", i), 32'(seen_ids.size() > i ? seen_ids[i] : -1), 32'(i % 4));
        end
        drain();

        // Backpressure: two active requesters, output stalled for 5 cycles
        seen_ids.delete();
        out_ready = 1'b0;
        rand_mode = 1; rand_mask = 4'b1010; rand_pct = 100;
        refill();
        drive();
        a0 = n_acc_dut;
        repeat (5) cycle();
        chk("bp_accepts", 32'(n_acc_dut - a0), 32'd2);
        chk("bp_no_ready", 32'(req_ready), 32'd0);
        rand_mode = 0;
        out_ready = 1'b1;
        repeat (8) cycle();
        chk("bp_drained", 32'(seen_ids.size()), 32'd4);
        drain();

        // Reset mid-flight with both stages valid
        out_ready = 1'b0;
        post(1, rand_operand());
        post(2, rand_operand());
        cyc = 0;
        while ((pipe.size() < 2) && (cyc < 10)) begin
            cycle();
            cyc++;
        end
        chk("mid_pipe_full", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_async", 32'(out_valid), 32'd0);
        pipe.delete();
        m_rr = 0;
        pend = '0;
        post(3, rand_operand());
        post(1, rand_operand());
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        chk("mid_first_grant", 32'(req_ready), 32'b0010);
        drain();

        // Randomized traffic with random backpressure
        rand_mode = 1; rand_mask = '1; rand_pct = 40;
        for (int c = 0; c < 600; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        rand_mode = 0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
